arb_counter_bank: RTL

//  Bank of NCH independent up/down counters for the encdec8b10b arbitration path, one per requesting channel.

---
 rtl/arb_counter_pkg.sv | 13 +
 rtl/arb_counter_chan.sv | 58 +++++
 rtl/arb_counter_bank.sv | 78 +++++++
 3 files changed

// File: rtl/arb_counter_pkg.sv
// Shared types and helpers for the arbitration counter bank.
package arb_counter_pkg;

    typedef enum logic {SAT, WRAP} cnt_mode_t;

    localparam int unsigned DEF_NBITS = 4;
    localparam int unsigned DEF_NCH   = 4;

    function automatic int unsigned cnt_max(input int unsigned nbits);
        return (32'd1 << nbits) - 32'd1;
    endfunction

endpackage

// File: rtl/arb_counter_chan.sv
// One up/down counter channel with sticky over/underflow flags and threshold decode.
module arb_counter_chan
    import arb_counter_pkg::*;
#(
    parameter int unsigned NBITS = DEF_NBITS,
    parameter cnt_mode_t   MODE  = SAT
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    input  logic             dec,
    input  logic             clear,
    input  logic             load,
    input  logic [NBITS-1:0] load_val,
    input  logic [NBITS-1:0] thresh,
    output logic [NBITS-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             thresh_hit,
    output logic             ovf,
    output logic             udf
);

    localparam logic [NBITS-1:0] MAX = NBITS'(cnt_max(NBITS));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !dec) begin
            if (count == MAX) begin
                ovf <= 1'b1;
                if (MODE == WRAP) count <= '0;
            end else begin
                count <= count + NBITS'(1);
            end
        end else if (dec && !inc) begin
            if (count == '0) begin
                udf <= 1'b1;
                if (MODE == WRAP) count <= MAX;
            end else begin
                count <= count - NBITS'(1);
            end
        end
    end

    assign full       = (count == MAX);
    assign empty      = (count == '0);
    assign thresh_hit = (count >= thresh);

endmodule

// File: rtl/arb_counter_bank.sv
// Bank of per-channel arbitration counters plus a registered largest-count finder.
module arb_counter_bank
    import arb_counter_pkg::*;
#(
    parameter int unsigned NBITS = DEF_NBITS,
    parameter int unsigned NCH   = DEF_NCH,
    parameter cnt_mode_t   MODE  = SAT
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NCH-1:0]           inc,
    input  logic [NCH-1:0]           dec,
    input  logic [NCH-1:0]           clear,
    input  logic [NCH-1:0]           load,
    input  logic [NCH*NBITS-1:0]     load_val,
    input  logic [NBITS-1:0]         thresh,
    output logic [NCH*NBITS-1:0]     count,
    output logic [NCH-1:0]           full,
    output logic [NCH-1:0]           empty,
    output logic [NCH-1:0]           thresh_hit,
    output logic [NCH-1:0]           ovf,
    output logic [NCH-1:0]           udf,
    output logic [$clog2(NCH)-1:0]   max_idx,
    output logic [NBITS-1:0]         max_val
);

    localparam int unsigned IW = $clog2(NCH);

    logic [NBITS-1:0] cnt [NCH];
    logic [IW-1:0]    best_idx;
    logic [NBITS-1:0] best_val;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        arb_counter_chan #(
            .NBITS (NBITS),
            .MODE  (MODE)
        ) u_chan (
            .CLK        (CLK),
            .nRST       (nRST),
            .inc        (inc[g]),
            .dec        (dec[g]),
            .clear      (clear[g]),
            .load       (load[g]),
            .load_val   (load_val[g*NBITS +: NBITS]),
            .thresh     (thresh),
            .count      (cnt[g]),
            .full       (full[g]),
            .empty      (empty[g]),
            .thresh_hit (thresh_hit[g]),
            .ovf        (ovf[g]),
            .udf        (udf[g])
        );
        assign count[g*NBITS +: NBITS] = cnt[g];
    end

    // Strict '>' keeps the earliest channel on ties; all-zero leaves index 0.
    always_comb begin
        best_idx = '0;
        best_val = cnt[0];
        for (int unsigned i = 1; i < NCH; i++) begin
            if (cnt[i] > best_val) begin
                best_val = cnt[i];
                best_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            max_idx <= '0;
            max_val <= '0;
        end else begin
            max_idx <= best_idx;
            max_val <= best_val;
        end
    end

endmodule
